hue_sequencer: RTL and testbench

//  Colour-wheel phase sequencer feeding three fade-channel stages (R, G, B).
//  - Steps through six hue phases, each PHASE_CYCLES clocks long.
//  - Emits a 3-bit fade command per channel: 0 = INC, 1 = DEC, 2 = HOLD.
//  - Together the channels trace the wheel R -> Y -> G -> C -> B -> M -> R.
//  - Sits directly upstream of the per-channel faders that drive the PWM.

---
 rtl/hue_seq_if.sv | 25 ++
 rtl/hue_sequencer.sv | 154 +++++++++++++++
 tb/tb_hue_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hue_seq_if.sv
// Control and fade-command bundle for the hue sequencer.
// The master drives run control; the slave returns commands and strobes.
interface hue_seq_if;
  logic       en;
  logic       restart;
  logic       dir;
  logic [2:0] r_cmd;
  logic [2:0] g_cmd;
  logic [2:0] b_cmd;
  logic [2:0] phase;
  logic       phase_stb;
  logic       wrap_stb;

  modport master (
    output en, restart, dir,
    input  r_cmd, g_cmd, b_cmd,
    input  phase, phase_stb, wrap_stb
  );

  modport slave (
    input  en, restart, dir,
    output r_cmd, g_cmd, b_cmd,
    output phase, phase_stb, wrap_stb
  );
endinterface

// File: rtl/hue_sequencer.sv
// Six-phase colour-wheel sequencer issuing INC/DEC/HOLD per RGB fader.
// Define HUE_SEQ_REVERSE_EN to build the dir-controlled reverse walk.
module hue_sequencer #(
  parameter int PHASE_CYCLES = 2000000,
  parameter int START_PHASE  = 0
) (
  input logic     clk,
  input logic     rst_n,
  hue_seq_if.slave bus
);
  localparam int CW = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);
  localparam logic [2:0] P0  = 3'(START_PHASE);
  localparam logic [2:0] INC = 3'd0;
  localparam logic [2:0] DEC = 3'd1;
  localparam logic [2:0] HLD = 3'd2;
  localparam logic [8:0] ALL_HOLD = {HLD, HLD, HLD};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  function automatic logic [8:0] row(
    input logic [2:0] p,
    input logic       rev
  );
    logic [2:0] i;
    logic [2:0] d;
    i = rev ? DEC : INC;
    d = rev ? INC : DEC;
    case (p)
      3'd0:    row = {HLD, i,   HLD};
      3'd1:    row = {d,   HLD, HLD};
      3'd2:    row = {HLD, HLD, i};
      3'd3:    row = {HLD, d,   HLD};
      3'd4:    row = {i,   HLD, HLD};
      3'd5:    row = {HLD, HLD, d};
      default: row = ALL_HOLD;
    endcase
  endfunction

  function automatic logic [2:0] step(
    input logic [2:0] p,
    input logic       rev
  );
    if (rev) step = (p == 3'd0) ? 3'd5 : p - 3'd1;
    else     step = (p == 3'd5) ? 3'd0 : p + 3'd1;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      phase_q, phase_d;
  logic [8:0]      cmd_q, cmd_d;
  logic            pstb_q, pstb_d;
  logic            wstb_q, wstb_d;
  logic            rev_now;
  logic            dir_q;
  logic            boundary;
  logic [2:0]      nxt_phase;
  logic            wraps;

  assign boundary = (state_q == RUN) && bus.en &&
                    !bus.restart && (count_q == LAST);
  assign nxt_phase = step(phase_q, rev_now);
  assign wraps = rev_now ? (phase_q == 3'd0)
                         : (phase_q == 3'd5);

`ifdef HUE_SEQ_REVERSE_EN
  // Direction latches only where a phase is entered.
  assign rev_now = bus.dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dir_q <= 1'b0;
    else if (bus.restart || boundary)
      dir_q <= bus.dir;
  end
`else
  logic unused_dir;
  assign unused_dir = bus.dir;
  assign rev_now    = 1'b0;
  assign dir_q      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    phase_d = phase_q;
    cmd_d   = cmd_q;
    pstb_d  = 1'b0;
    wstb_d  = 1'b0;
    if (bus.restart) begin
      phase_d = P0;
      count_d = '0;
      state_d = bus.en ? RUN : IDLE;
      pstb_d  = bus.en;
      cmd_d   = bus.en ? row(P0, rev_now) : ALL_HOLD;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.en) begin
            state_d = RUN;
            pstb_d  = 1'b1;
            cmd_d   = row(phase_q, dir_q);
          end
        end
        RUN: begin
          if (!bus.en) begin
            state_d = PAUSE;
            cmd_d   = ALL_HOLD;
          end else if (count_q == LAST) begin
            count_d = '0;
            phase_d = nxt_phase;
            pstb_d  = 1'b1;
            wstb_d  = wraps;
            cmd_d   = row(nxt_phase, rev_now);
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        PAUSE: begin
          if (bus.en) begin
            state_d = RUN;
            cmd_d   = row(phase_q, dir_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      phase_q <= P0;
      cmd_q   <= ALL_HOLD;
      pstb_q  <= 1'b0;
      wstb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      phase_q <= phase_d;
      cmd_q   <= cmd_d;
      pstb_q  <= pstb_d;
      wstb_q  <= wstb_d;
    end
  end

  assign bus.r_cmd     = cmd_q[8:6];
  assign bus.g_cmd     = cmd_q[5:3];
  assign bus.b_cmd     = cmd_q[2:0];
  assign bus.phase     = phase_q;
  assign bus.phase_stb = pstb_q;
  assign bus.wrap_stb  = wstb_q;
endmodule

// File: tb/tb_hue_sequencer.sv
// Directed bench for hue_sequencer with 4-clock phases.
// Observed word is {r, g, b, phase, phase_stb, wrap_stb}.
module tb_hue_sequencer;
  localparam logic [2:0] I = 3'd0;
  localparam logic [2:0] D = 3'd1;
  localparam logic [2:0] H = 3'd2;
  localparam logic [8:0] HOLD3 = {H, H, H};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hue_seq_if bus ();

  hue_sequencer #(
    .PHASE_CYCLES(4),
    .START_PHASE (0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [8:0] row_f [6];
  logic [13:0] obs;
  logic [13:0] exp_v;
  int n_run = 0;
  int n_fail = 0;

  assign obs = {bus.r_cmd, bus.g_cmd, bus.b_cmd,
                bus.phase, bus.phase_stb, bus.wrap_stb};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_v = {HOLD3, 3'd0, 1'b0, 1'b0};
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset k=%0d got %h expected %h", k, obs, exp_v);
      end
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_v = {HOLD3, 3'd0, 1'b0, 1'b0};
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL idle k=%0d got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_run();
    int p;
    bus.en = 1'b1;
    tick();
    exp_v = {row_f[0], 3'd0, 1'b1, 1'b0};
    n_run++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL run_start got %h expected %h", obs, exp_v);
    end
    for (int k = 1; k <= 24; k++) begin
      tick();
      p = (k / 4) % 6;
      exp_v = {row_f[p], 3'(p), (k % 4) == 0, k == 24};
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL run k=%0d got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_pause();
    repeat (10) tick();
    bus.en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      exp_v = {HOLD3, 3'd2, 1'b0, 1'b0};
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL pause k=%0d got %h expected %h", k, obs, exp_v);
      end
    end
    bus.en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_v = (k < 2) ? {row_f[2], 3'd2, 1'b0, 1'b0}
                      : {row_f[3], 3'd3, 1'b1, 1'b0};
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL resume k=%0d got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_restart();
    repeat (3) tick();
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    exp_v = {row_f[0], 3'd0, 1'b1, 1'b0};
    n_run++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL restart got %h expected %h", obs, exp_v);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_v = (k < 4) ? {row_f[0], 3'd0, 1'b0, 1'b0}
                      : {row_f[1], 3'd1, 1'b1, 1'b0};
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL restart_cnt k=%0d got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (13) tick();
    exp_v = {row_f[4], 3'd4, 1'b0, 1'b0};
    n_run++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL pre_areset got %h expected %h", obs, exp_v);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_v = {HOLD3, 3'd0, 1'b0, 1'b0};
    n_run++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL areset got %h expected %h", obs, exp_v);
    end
    bus.en = 1'b0;
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL post_areset k=%0d got %h expected %h", k, obs, exp_v);
      end
    end
    bus.en = 1'b1;
    tick();
    exp_v = {row_f[0], 3'd0, 1'b1, 1'b0};
    n_run++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL rerun got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_direction();
    logic [13:0] e [4];
`ifdef HUE_SEQ_REVERSE_EN
    e[0] = {H, H, I, 3'd5, 1'b1, 1'b1};
    e[1] = {D, H, H, 3'd4, 1'b1, 1'b0};
    e[2] = {D, H, H, 3'd4, 1'b0, 1'b0};
    e[3] = {H, H, D, 3'd5, 1'b1, 1'b0};
`else
    e[0] = {row_f[1], 3'd1, 1'b1, 1'b0};
    e[1] = {row_f[2], 3'd2, 1'b1, 1'b0};
    e[2] = {row_f[2], 3'd2, 1'b0, 1'b0};
    e[3] = {row_f[3], 3'd3, 1'b1, 1'b0};
`endif
    repeat (3) tick();
    bus.dir = 1'b1;
    tick();
    n_run++;
    if (obs !== e[0]) begin
      n_fail++;
      $display("FAIL dir_first got %h expected %h", obs, e[0]);
    end
    repeat (4) tick();
    n_run++;
    if (obs !== e[1]) begin
      n_fail++;
      $display("FAIL dir_second got %h expected %h", obs, e[1]);
    end
    bus.dir = 1'b0;
    repeat (3) tick();
    n_run++;
    if (obs !== e[2]) begin
      n_fail++;
      $display("FAIL dir_mid got %h expected %h", obs, e[2]);
    end
    tick();
    n_run++;
    if (obs !== e[3]) begin
      n_fail++;
      $display("FAIL dir_next got %h expected %h", obs, e[3]);
    end
  endtask

  task automatic test_restart_idle();
    bus.en = 1'b0;
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    exp_v = {HOLD3, 3'd0, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      n_run++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL restart_idle k=%0d got %h expected %h", k, obs, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    row_f[0] = {H, I, H};
    row_f[1] = {D, H, H};
    row_f[2] = {H, H, I};
    row_f[3] = {H, D, H};
    row_f[4] = {I, H, H};
    row_f[5] = {H, H, D};
    bus.en = 1'b0;
    bus.restart = 1'b0;
    bus.dir = 1'b0;
    test_reset();
    test_run();
    test_pause();
    test_restart();
    test_async_reset();
    test_direction();
    test_restart_idle();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
